// File: rtl/change_pkg.sv
// Shared coin constants, coin/state encodings and the coin-value helper for
// the sequential change dispenser.
package change_pkg;

  localparam int unsigned QUARTER = 25;
  localparam int unsigned DIME    = 10;
  localparam int unsigned NICKEL  = 5;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'd0,
    COIN_NICKEL  = 2'd1,
    COIN_DIME    = 2'd2,
    COIN_QUARTER = 2'd3
  } coin_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  function automatic logic [4:0] coin_value(input coin_t c);
    case (c)
      COIN_QUARTER: coin_value = 5'(QUARTER);
      COIN_DIME:    coin_value = 5'(DIME);
      COIN_NICKEL:  coin_value = 5'(NICKEL);
      default:      coin_value = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Three saturating per-denomination inventory counters (nickel, dime, quarter)
// with a refill port and a one-coin decrement port; reset to full.
module coin_inventory #(
  parameter int INV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refill_valid,
  input  logic [1:0]       refill_type,
  input  logic [INV_W-1:0] refill_count,
  input  logic             dec_valid,
  input  logic [1:0]       dec_type,
  output logic [INV_W-1:0] inv_q,
  output logic [INV_W-1:0] inv_d,
  output logic [INV_W-1:0] inv_n
);

  // Counter gi serves coin type gi+1, so type 0 (none) never matches.
  for (genvar gi = 0; gi < 3; gi++) begin : gen_cnt
    localparam logic [1:0] CNT_TYPE = 2'(gi + 1);

    logic [INV_W-1:0] cnt_q;
    logic [INV_W-1:0] cnt_d;
    logic [INV_W:0]   add_v;
    logic [INV_W:0]   sub_v;
    logic [INV_W:0]   sum_v;

    // The decrement is only issued when the count is non-zero, so the sum
    // never underflows; overflow past all-ones saturates.
    always_comb begin
      add_v = '0;
      sub_v = '0;
      if (refill_valid && (refill_type == CNT_TYPE)) begin
        add_v = {1'b0, refill_count};
      end
      if (dec_valid && (dec_type == CNT_TYPE)) begin
        sub_v = (INV_W + 1)'(1);
      end
      sum_v = {1'b0, cnt_q} + add_v - sub_v;
      cnt_d = sum_v[INV_W] ? '1 : sum_v[INV_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '1;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign inv_n = gen_cnt[0].cnt_q;
  assign inv_d = gen_cnt[1].cnt_q;
  assign inv_q = gen_cnt[2].cnt_q;

endmodule

// File: rtl/change_dispenser_seq.sv
// Greedy coin-by-coin change dispenser (quarter, dime, nickel) with a
// valid/ready request port and coin port. Define CHANGE_INVENTORY_EN to track
// per-denomination inventory; otherwise inventory is unlimited.
module change_dispenser_seq
  import change_pkg::*;
#(
  parameter int AMOUNT_W = 32,
  parameter int CNT_W    = 9,
  parameter int INV_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [AMOUNT_W-1:0] req_amount,
  output logic                coin_valid,
  input  logic                coin_ready,
  output logic [1:0]          coin_type,
  output logic                done,
  output logic [CNT_W-1:0]    quarters,
  output logic [CNT_W-1:0]    dimes,
  output logic [CNT_W-1:0]    nickels,
  output logic [AMOUNT_W-1:0] residue,
  input  logic                refill_valid,
  input  logic [1:0]          refill_type,
  input  logic [INV_W-1:0]    refill_count,
  output logic [INV_W-1:0]    inv_q,
  output logic [INV_W-1:0]    inv_d,
  output logic [INV_W-1:0]    inv_n
);

  state_t              state_q, state_d;
  logic [AMOUNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0]    qtr_cnt_q, qtr_cnt_d;
  logic [CNT_W-1:0]    dim_cnt_q, dim_cnt_d;
  logic [CNT_W-1:0]    nic_cnt_q, nic_cnt_d;
  logic [AMOUNT_W-1:0] residue_q, residue_d;

  coin_t sel_coin;
  logic  coin_fire;
  logic  avail_q, avail_d, avail_n;

`ifdef CHANGE_INVENTORY_EN
  coin_inventory #(
    .INV_W(INV_W)
  ) u_inventory (
    .clk         (clk),
    .rst         (rst),
    .refill_valid(refill_valid),
    .refill_type (refill_type),
    .refill_count(refill_count),
    .dec_valid   (coin_fire),
    .dec_type    (sel_coin),
    .inv_q       (inv_q),
    .inv_d       (inv_d),
    .inv_n       (inv_n)
  );

  assign avail_q = (inv_q != '0);
  assign avail_d = (inv_d != '0);
  assign avail_n = (inv_n != '0);
`else
  logic unused_refill;

  assign unused_refill = ^{refill_valid, refill_type, refill_count};
  assign inv_q   = '1;
  assign inv_d   = '1;
  assign inv_n   = '1;
  assign avail_q = 1'b1;
  assign avail_d = 1'b1;
  assign avail_n = 1'b1;
`endif

  // Selection depends only on registered state and inventory, so it stays
  // put during a stall unless a refill makes a larger coin available.
  always_comb begin
    sel_coin = COIN_NONE;
    if (state_q == ST_DISPENSE) begin
      if ((remaining_q >= AMOUNT_W'(QUARTER)) && avail_q && (qtr_cnt_q != '1)) begin
        sel_coin = COIN_QUARTER;
      end else if ((remaining_q >= AMOUNT_W'(DIME)) && avail_d && (dim_cnt_q != '1)) begin
        sel_coin = COIN_DIME;
      end else if ((remaining_q >= AMOUNT_W'(NICKEL)) && avail_n && (nic_cnt_q != '1)) begin
        sel_coin = COIN_NICKEL;
      end
    end
  end

  assign coin_valid = (sel_coin != COIN_NONE);
  assign coin_type  = sel_coin;
  assign coin_fire  = coin_valid && coin_ready;
  assign req_ready  = (state_q == ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign quarters   = qtr_cnt_q;
  assign dimes      = dim_cnt_q;
  assign nickels    = nic_cnt_q;
  assign residue    = residue_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    qtr_cnt_d   = qtr_cnt_q;
    dim_cnt_d   = dim_cnt_q;
    nic_cnt_d   = nic_cnt_q;
    residue_d   = residue_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          remaining_d = req_amount;
          qtr_cnt_d   = '0;
          dim_cnt_d   = '0;
          nic_cnt_d   = '0;
          residue_d   = '0;
          state_d     = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        if (sel_coin == COIN_NONE) begin
          residue_d = remaining_q;
          state_d   = ST_DONE;
        end else if (coin_ready) begin
          remaining_d = remaining_q - AMOUNT_W'(coin_value(sel_coin));
          case (sel_coin)
            COIN_QUARTER: qtr_cnt_d = qtr_cnt_q + 1'b1;
            COIN_DIME:    dim_cnt_d = dim_cnt_q + 1'b1;
            default:      nic_cnt_d = nic_cnt_q + 1'b1;
          endcase
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      qtr_cnt_q   <= '0;
      dim_cnt_q   <= '0;
      nic_cnt_q   <= '0;
      residue_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      qtr_cnt_q   <= qtr_cnt_d;
      dim_cnt_q   <= dim_cnt_d;
      nic_cnt_q   <= nic_cnt_d;
      residue_q   <= residue_d;
    end
  end

endmodule

// File: tb/tb_change_dispenser_seq.sv
// Table-driven bench for change_dispenser_seq: expected coins are queued per
// request and checked at each coin handshake; CHANGE_INVENTORY_EN adds refill tests.
module tb_change_dispenser_seq;

  localparam int AMOUNT_W = 32;
  localparam int CNT_W    = 9;
  localparam int INV_W    = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [AMOUNT_W-1:0] req_amount = '0;
  logic                coin_valid;
  logic                coin_ready = 1'b0;
  logic [1:0]          coin_type;
  logic                done;
  logic [CNT_W-1:0]    quarters, dimes, nickels;
  logic [AMOUNT_W-1:0] residue;
  logic                refill_valid = 1'b0;
  logic [1:0]          refill_type = '0;
  logic [INV_W-1:0]    refill_count = '0;
  logic [INV_W-1:0]    inv_q, inv_d, inv_n;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_coins[$];

  typedef struct {
    string       name;
    logic [31:0] amt;
    int          q;
    int          d;
    int          n;
    logic [31:0] res;
    logic [15:0] pat;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  change_dispenser_seq #(
    .AMOUNT_W(AMOUNT_W),
    .CNT_W   (CNT_W),
    .INV_W   (INV_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_amount  (req_amount),
    .coin_valid  (coin_valid),
    .coin_ready  (coin_ready),
    .coin_type   (coin_type),
    .done        (done),
    .quarters    (quarters),
    .dimes       (dimes),
    .nickels     (nickels),
    .residue     (residue),
    .refill_valid(refill_valid),
    .refill_type (refill_type),
    .refill_count(refill_count),
    .inv_q       (inv_q),
    .inv_d       (inv_d),
    .inv_n       (inv_n)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, ".req_ready"}, 64'(req_ready), 64'd1);
    chk({nm, ".coin_valid"}, 64'(coin_valid), 64'd0);
    chk({nm, ".coin_type"}, 64'(coin_type), 64'd0);
    chk({nm, ".done"}, 64'(done), 64'd0);
    chk({nm, ".counts"}, 64'({quarters, dimes, nickels}), 64'd0);
    chk({nm, ".residue"}, 64'(residue), 64'd0);
    chk({nm, ".inv"}, 64'({inv_q, inv_d, inv_n}), 64'hFF_FFFF);
  endtask

  // Issue one request and follow it to done, checking every offered coin
  // against the queued expectation. abort_after>0 asserts reset once that
  // many coins have been handshaken.
  task automatic run_req(input string nm, input logic [31:0] amt, input int eq,
                         input int ed, input int en, input logic [31:0] eres,
                         input logic [15:0] pat, input int abort_after);
    int cyc, offers, taken, done_cyc;
    bit saw_done;
    chk({nm, ".ready_before"}, 64'(req_ready), 64'd1);
    exp_coins.delete();
    for (int i = 0; i < eq; i++) exp_coins.push_back(2'd3);
    for (int i = 0; i < ed; i++) exp_coins.push_back(2'd2);
    for (int i = 0; i < en; i++) exp_coins.push_back(2'd1);
    req_valid  = 1'b1;
    req_amount = amt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1; offers = 0; taken = 0; done_cyc = -1;
    while (cyc < 3000) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      coin_ready = 1'b0;
      if (coin_valid) begin
        if (exp_coins.size() == 0) begin
          chk({nm, ".extra_coin"}, 64'(coin_type), 64'd0);
        end else begin
          chk({nm, ".coin_type"}, 64'(coin_type), 64'(exp_coins[0]));
        end
        coin_ready = (offers < 16) ? pat[offers] : 1'b1;
        offers++;
      end
      @(posedge clk); #1;
      if (coin_ready) begin
        if (exp_coins.size() != 0) void'(exp_coins.pop_front());
        taken++;
      end
      coin_ready = 1'b0;
      cyc++;
      if (abort_after > 0 && taken == abort_after) begin
        rst = 1'b0;
        #1;
        check_reset_state({nm, ".mid_reset"});
        exp_coins.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (done) saw_done = 1'b1;
          @(posedge clk); #1;
        end
        chk({nm, ".no_done_after_reset"}, 64'(saw_done), 64'd0);
        $display("req %s amt=%0d aborted after %0d coins", nm, amt, taken);
        return;
      end
    end
    if (done_cyc < 0) begin
      chk({nm, ".done_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({nm, ".done_cycle"}, 64'(done_cyc), 64'(offers + 2));
      chk({nm, ".quarters"}, 64'(quarters), 64'(eq));
      chk({nm, ".dimes"}, 64'(dimes), 64'(ed));
      chk({nm, ".nickels"}, 64'(nickels), 64'(en));
      chk({nm, ".residue"}, 64'(residue), 64'(eres));
      chk({nm, ".coins_left"}, 64'(exp_coins.size()), 64'd0);
    end
    @(posedge clk); #1;
    chk({nm, ".ready_after"}, 64'({done, req_ready}), 64'b01);
    $display("req %s amt=%0d q=%0d d=%0d n=%0d res=%0d done_cyc=%0d",
             nm, amt, quarters, dimes, nickels, residue, done_cyc);
  endtask

  task automatic do_refill(input logic [1:0] t, input logic [INV_W-1:0] c);
    refill_valid = 1'b1;
    refill_type  = t;
    refill_count = c;
    @(posedge clk); #1;
    refill_valid = 1'b0;
    refill_type  = '0;
    refill_count = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    tbl[0] = '{"amt65",  32'd65, 2, 1, 1, 32'd0, 16'hFFFF};
    tbl[1] = '{"amt67",  32'd67, 2, 1, 1, 32'd2, 16'hFFFF};
    tbl[2] = '{"amt40s", 32'd40, 1, 1, 1, 32'd0, 16'hFFEC};
    tbl[3] = '{"amt0",   32'd0,  0, 0, 0, 32'd0, 16'hFFFF};
    tbl[4] = '{"amt60",  32'd60, 2, 1, 0, 32'd0, 16'hFFFF};
    tbl[5] = '{"amt4",   32'd4,  0, 0, 0, 32'd4, 16'hFFFF};
    tbl[6] = '{"amt30",  32'd30, 1, 0, 1, 32'd0, 16'hFFFF};
    tbl[7] = '{"amt19",  32'd19, 0, 1, 1, 32'd4, 16'hFFFF};

    #1;
    check_reset_state("in_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("post_reset");

    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].name, tbl[i].amt, tbl[i].q, tbl[i].d, tbl[i].n,
              tbl[i].res, tbl[i].pat, 0);
    end

    run_req("reset_mid", 32'd100, 4, 0, 0, 32'd0, 16'hFFFF, 2);
    run_req("after_reset25", 32'd25, 1, 0, 0, 32'd0, 16'hFFFF, 0);

`ifdef CHANGE_INVENTORY_EN
    do_reset();
    run_req("drain_q", 32'd6350, 254, 0, 0, 32'd0, 16'hFFFF, 0);
    chk("drain_q.inv_q", 64'(inv_q), 64'd1);
    run_req("short_q60", 32'd60, 1, 3, 1, 32'd0, 16'hFFFF, 0);
    chk("short_q60.inv", 64'({inv_q, inv_d, inv_n}), 64'({8'd0, 8'd252, 8'd254}));
    do_refill(2'd3, 8'd3);
    chk("refill_q.inv_q", 64'(inv_q), 64'd3);
    do_refill(2'd0, 8'd10);
    chk("refill_none.inv", 64'({inv_q, inv_d, inv_n}), 64'({8'd3, 8'd252, 8'd254}));
    do_refill(2'd2, 8'd200);
    chk("refill_sat.inv_d", 64'(inv_d), 64'd255);
`else
    run_req("cnt_sat", 32'd12800, 511, 2, 1, 32'd0, 16'hFFFF, 0);
    do_refill(2'd1, 8'd5);
    chk("tied_inv", 64'({inv_q, inv_d, inv_n}), 64'hFF_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
